// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared types and constants for mem_bus_arbiter:
//   state_t    - arbiter FSM states
//   ERR_DATA   - read data returned to a master whose access timed out
//   bus_req_t  - one master request as seen by the arbiter (address, write
//                data, strobes, direction)
// The struct is sized for the widest supported bus. Instances whose ADDR_W or
// DATA_W are narrower zero-pad into it. ADDR_W must not exceed MAX_ADDR_W, and
// DATA_W must not exceed MAX_DATA_W.
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 128;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] wdata;
        logic [MAX_STRB_W-1:0] wstrb;
        logic                  is_write;
    } bus_req_t;

endpackage : mem_bus_pkg

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin pick. This block is purely combinational.
//   req[1:0]    in   request vector, bit N = master N
//   last_grant  in   index of the master granted most recently
//   grant[1:0]  out  one-hot grant; all zero when nothing requests
// On a tie, the master that was not granted last wins.
// -----------------------------------------------------------------------------
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: assign a default first so that every path drives grant;
        // otherwise a latch is inferred.
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule : rr_arbiter_2

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one slave memory port between two masters.
// The arbiter serves one transaction at a time and uses round-robin on ties.
// A master that requests read and write together is served its read first.
//
// Ports
//   clock, resetn               clock and asynchronous active-low reset. The
//                               reset is expected to deassert synchronously
//                               to clock (it is synchronised upstream).
//   mN_ren/raddr                master N read request (held until response)
//   mN_rdata/rvalid             master N read data and one-cycle done pulse
//   mN_wen/waddr/wdata/wstrb    master N write request (held until response)
//   mN_wready                   master N one-cycle write-done pulse
//   mN_err                      set together with rvalid/wready on a timeout
//   s_ren/raddr, s_rdata/rvalid shared read port. Outputs are registered.
//   s_wen/waddr/wdata/wstrb     shared write port. Outputs are registered.
//   s_wready                    shared write response
//
// Timing
//   Cycle after a grant: s_ren or s_wen is high.
//   Cycle after s_rvalid or s_wready is sampled: RESP, with a one-cycle pulse
//   to the owner.
//   Cycle after RESP: IDLE.
//
// If TIMEOUT > 0 and TIMEOUT cycles pass with no response, the transaction
// ends. The owner then gets the done pulse with err set, and reads return
// ERR_DATA. A response that arrives in the same cycle as the timeout wins.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                resetn,

    input  logic                m0_ren,
    input  logic [ADDR_W-1:0]   m0_raddr,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rvalid,
    input  logic                m0_wen,
    input  logic [ADDR_W-1:0]   m0_waddr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_wready,
    output logic                m0_err,

    input  logic                m1_ren,
    input  logic [ADDR_W-1:0]   m1_raddr,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rvalid,
    input  logic                m1_wen,
    input  logic [ADDR_W-1:0]   m1_waddr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_wready,
    output logic                m1_err,

    output logic                s_ren,
    output logic [ADDR_W-1:0]   s_raddr,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rvalid,
    output logic                s_wen,
    output logic [ADDR_W-1:0]   s_waddr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wready
);

    localparam int STRB_W = DATA_W / 8;

    // The counter only has to reach TIMEOUT. With the timeout disabled, a
    // single idle bit keeps the declarations legal.
    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TMO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic             owner;
    logic             last_grant;
    logic [CNT_W-1:0] tmo_cnt;
    logic [1:0]       want;
    logic [1:0]       grant;
    bus_req_t         sel_req;
    logic             do_grant;
    logic             do_finish;
    logic             finish_err;
    logic             tmo_hit;
    logic [DATA_W-1:0] rsp_data;

    // A master competes while it holds either request.
    // Inside that master, the read is served first.
    assign want = {m1_ren | m1_wen, m0_ren | m0_wen};

    rr_arbiter_2 u_rr (
        .req        (want),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Request of the winning master, packed into the common struct.
    always_comb begin
        sel_req = '0;
        if (grant[1]) begin
            sel_req.is_write = !m1_ren;
            sel_req.addr     = m1_ren ? MAX_ADDR_W'(m1_raddr) : MAX_ADDR_W'(m1_waddr);
            sel_req.wdata    = MAX_DATA_W'(m1_wdata);
            sel_req.wstrb    = MAX_STRB_W'(m1_wstrb);
        end else begin
            sel_req.is_write = !m0_ren;
            sel_req.addr     = m0_ren ? MAX_ADDR_W'(m0_raddr) : MAX_ADDR_W'(m0_waddr);
            sel_req.wdata    = MAX_DATA_W'(m0_wdata);
            sel_req.wstrb    = MAX_STRB_W'(m0_wstrb);
        end
    end

    // The padding bits of the struct above the bus widths are always zero.
    logic unused_req_bits;
    assign unused_req_bits = ^sel_req;

    // The counter holds the number of cycles already spent in READ or WRITE.
    // On the edge that ends cycle TIMEOUT, the timeout fires.
    assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);
    assign rsp_data = finish_err ? DATA_W'(ERR_DATA) : s_rdata;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples values from before the edge.
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and control strobes for the datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_finish  = 1'b0;
        finish_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (|grant) begin
                    do_grant   = 1'b1;
                    state_next = sel_req.is_write ? WRITE : READ;
                end
            end
            READ: begin
                if (s_rvalid) begin
                    do_finish  = 1'b1;
                    state_next = RESP;
                end else if (tmo_hit) begin
                    do_finish  = 1'b1;
                    finish_err = 1'b1;
                    state_next = RESP;
                end
            end
            WRITE: begin
                if (s_wready) begin
                    do_finish  = 1'b1;
                    state_next = RESP;
                end else if (tmo_hit) begin
                    do_finish  = 1'b1;
                    finish_err = 1'b1;
                    state_next = RESP;
                end
            end
            // The owner drops its request during the next IDLE cycle. For
            // that reason RESP never grants.
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: grant bookkeeping, shared-port registers, master responses
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            s_ren      <= 1'b0;
            s_raddr    <= '0;
            s_wen      <= 1'b0;
            s_waddr    <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
            m0_rdata   <= '0;
            m0_rvalid  <= 1'b0;
            m0_wready  <= 1'b0;
            m0_err     <= 1'b0;
            m1_rdata   <= '0;
            m1_rvalid  <= 1'b0;
            m1_wready  <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            // Pulses are set only on the edge into RESP.
            // That makes each pulse exactly one cycle long.
            m0_rvalid <= 1'b0;
            m0_wready <= 1'b0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_wready <= 1'b0;
            m1_err    <= 1'b0;

            if (do_grant) begin
                owner      <= grant[1];
                last_grant <= grant[1];
                tmo_cnt    <= '0;
                s_ren      <= !sel_req.is_write;
                s_wen      <= sel_req.is_write;
                if (sel_req.is_write) begin
                    s_waddr <= sel_req.addr[ADDR_W-1:0];
                    s_wdata <= sel_req.wdata[DATA_W-1:0];
                    s_wstrb <= sel_req.wstrb[STRB_W-1:0];
                end else begin
                    s_raddr <= sel_req.addr[ADDR_W-1:0];
                end
            end else if ((state == READ || state == WRITE) && TMO_EN && tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if (do_finish) begin
                s_ren <= 1'b0;
                s_wen <= 1'b0;
                if (state == READ) begin
                    if (owner) begin
                        m1_rvalid <= 1'b1;
                        m1_err    <= finish_err;
                        m1_rdata  <= rsp_data;
                    end else begin
                        m0_rvalid <= 1'b1;
                        m0_err    <= finish_err;
                        m0_rdata  <= rsp_data;
                    end
                end else begin
                    if (owner) begin
                        m1_wready <= 1'b1;
                        m1_err    <= finish_err;
                    end else begin
                        m0_wready <= 1'b1;
                        m0_err    <= finish_err;
                    end
                end
            end
        end
    end

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter with TIMEOUT = 8.
// The bench plays both masters and the slave.
// Single transactions come from a vector table.
// Ties, read+write ordering and reset mid-read are hand-written sequences.
// Inputs change 1 time unit after the rising edge, and outputs are sampled at
// the same point.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TIMEOUT = 8;

    logic              clock = 1'b0;
    logic              resetn;

    logic              m0_ren, m0_wen, m0_rvalid, m0_wready, m0_err;
    logic [ADDR_W-1:0] m0_raddr, m0_waddr;
    logic [DATA_W-1:0] m0_rdata, m0_wdata;
    logic [STRB_W-1:0] m0_wstrb;

    logic              m1_ren, m1_wen, m1_rvalid, m1_wready, m1_err;
    logic [ADDR_W-1:0] m1_raddr, m1_waddr;
    logic [DATA_W-1:0] m1_rdata, m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;

    logic              s_ren, s_rvalid, s_wen, s_wready;
    logic [ADDR_W-1:0] s_raddr, s_waddr;
    logic [DATA_W-1:0] s_rdata, s_wdata;
    logic [STRB_W-1:0] s_wstrb;

    mem_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .m0_ren    (m0_ren),
        .m0_raddr  (m0_raddr),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m0_wen    (m0_wen),
        .m0_waddr  (m0_waddr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_wready (m0_wready),
        .m0_err    (m0_err),
        .m1_ren    (m1_ren),
        .m1_raddr  (m1_raddr),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .m1_wen    (m1_wen),
        .m1_waddr  (m1_waddr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_wready (m1_wready),
        .m1_err    (m1_err),
        .s_ren     (s_ren),
        .s_raddr   (s_raddr),
        .s_rdata   (s_rdata),
        .s_rvalid  (s_rvalid),
        .s_wen     (s_wen),
        .s_waddr   (s_waddr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wready  (s_wready)
    );

    always #5 clock = ~clock;

    // One single transaction.
    // delay = cycles the slave waits before responding; -1 = slave stays silent.
    typedef struct {
        bit          mst;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          delay;
        logic [31:0] resp;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_master(input bit mst, input logic ren, input logic wen,
                                input logic [31:0] raddr, input logic [31:0] waddr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
        if (mst) begin
            m1_ren = ren; m1_wen = wen; m1_raddr = raddr; m1_waddr = waddr;
            m1_wdata = wdata; m1_wstrb = wstrb;
        end else begin
            m0_ren = ren; m0_wen = wen; m0_raddr = raddr; m0_waddr = waddr;
            m0_wdata = wdata; m0_wstrb = wstrb;
        end
    endtask

    // {rvalid, wready, err} of one master
    function automatic logic [2:0] pulses(input bit mst);
        return mst ? {m1_rvalid, m1_wready, m1_err} : {m0_rvalid, m0_wready, m0_err};
    endfunction

    function automatic logic [31:0] rdata_of(input bit mst);
        return mst ? m1_rdata : m0_rdata;
    endfunction

    // Starts and ends just after an edge, with the FSM in IDLE.
    task automatic run_txn(input string tag, input vec_t v);
        int n;
        logic [2:0] exp_p;
        drive_master(v.mst, !v.wr, v.wr, v.addr, v.addr, v.wdata, v.strb);
        step();
        check({tag, ".s_req"}, {30'b0, s_ren, s_wen}, v.wr ? 32'd1 : 32'd2);
        if (v.wr) begin
            check({tag, ".s_waddr"}, s_waddr, v.addr);
            check({tag, ".s_wdata"}, s_wdata, v.wdata);
            check({tag, ".s_wstrb"}, {28'b0, s_wstrb}, {28'b0, v.strb});
        end else begin
            check({tag, ".s_raddr"}, s_raddr, v.addr);
        end
        if (v.delay < 0) begin
            n = 0;
            while ((s_ren || s_wen) && n < 4 * TIMEOUT) begin
                step();
                n++;
            end
            check({tag, ".tmo_len"}, n, TIMEOUT);
        end else begin
            repeat (v.delay) step();
            check({tag, ".s_hold"}, {30'b0, s_ren, s_wen}, v.wr ? 32'd1 : 32'd2);
            if (v.wr) s_wready = 1'b1;
            else begin
                s_rvalid = 1'b1;
                s_rdata  = v.resp;
            end
            step();
            s_rvalid = 1'b0;
            s_wready = 1'b0;
            s_rdata  = '0;
        end
        exp_p = {!v.wr, v.wr, v.exp_err};
        check({tag, ".pulse"}, pulses(v.mst), exp_p);
        check({tag, ".other_quiet"}, pulses(!v.mst), 0);
        check({tag, ".rdata"}, rdata_of(v.mst), v.exp_rdata);
        check({tag, ".s_dropped"}, {30'b0, s_ren, s_wen}, 0);
        step();
        drive_master(v.mst, 1'b0, 1'b0, v.addr, v.addr, v.wdata, v.strb);
        check({tag, ".pulse_end"}, pulses(v.mst), 0);
        step();
        check({tag, ".no_regrant"}, {30'b0, s_ren, s_wen}, 0);
    endtask

    // Serves one read while both masters may be requesting.
    // Afterwards the winner drops its request.
    task automatic serve_read(input string tag, input bit mst,
                              input logic [31:0] addr, input logic [31:0] resp);
        step();
        check({tag, ".s_ren"}, {31'b0, s_ren}, 1);
        check({tag, ".s_raddr"}, s_raddr, addr);
        s_rvalid = 1'b1;
        s_rdata  = resp;
        step();
        s_rvalid = 1'b0;
        check({tag, ".pulse"}, pulses(mst), 3'b100);
        check({tag, ".other_quiet"}, pulses(!mst), 0);
        check({tag, ".rdata"}, rdata_of(mst), resp);
        step();
        if (mst) m1_ren = 1'b0;
        else     m0_ren = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t solo;
        // Expected rdata of writes is the value the master last read.
        vecs[0] = '{mst:1'b0, wr:1'b0, addr:32'h100, wdata:32'h0, strb:4'h0, delay:3,
                    resp:32'h1234_5678, exp_err:1'b0, exp_rdata:32'h1234_5678};
        vecs[1] = '{mst:1'b1, wr:1'b1, addr:32'h200, wdata:32'hA5A5_A5A5, strb:4'h3, delay:1,
                    resp:32'h0, exp_err:1'b0, exp_rdata:32'h4444_4444};
        vecs[2] = '{mst:1'b1, wr:1'b0, addr:32'h204, wdata:32'h0, strb:4'h0, delay:0,
                    resp:32'hCAFE_F00D, exp_err:1'b0, exp_rdata:32'hCAFE_F00D};
        vecs[3] = '{mst:1'b0, wr:1'b1, addr:32'h300, wdata:32'h0102_0304, strb:4'hF, delay:7,
                    resp:32'h0, exp_err:1'b0, exp_rdata:32'h1234_5678};
        vecs[4] = '{mst:1'b0, wr:1'b0, addr:32'h400, wdata:32'h0, strb:4'h0, delay:-1,
                    resp:32'h0, exp_err:1'b1, exp_rdata:32'hDEAD_BEEF};
        vecs[5] = '{mst:1'b1, wr:1'b1, addr:32'h500, wdata:32'h600D_600D, strb:4'h8, delay:-1,
                    resp:32'h0, exp_err:1'b1, exp_rdata:32'hCAFE_F00D};
        vecs[6] = '{mst:1'b1, wr:1'b0, addr:32'h600, wdata:32'h0, strb:4'h0, delay:7,
                    resp:32'h0BAD_C0DE, exp_err:1'b0, exp_rdata:32'h0BAD_C0DE};
        vecs[7] = '{mst:1'b0, wr:1'b0, addr:32'h700, wdata:32'h0, strb:4'h0, delay:2,
                    resp:32'h5555_AAAA, exp_err:1'b0, exp_rdata:32'h5555_AAAA};

        resetn   = 1'b0;
        s_rvalid = 1'b0;
        s_wready = 1'b0;
        s_rdata  = '0;
        drive_master(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        drive_master(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);

        // Reset values
        #2;
        check("rst.s_ctrl", {30'b0, s_ren, s_wen}, 0);
        check("rst.s_raddr", s_raddr, 0);
        check("rst.s_waddr", s_waddr, 0);
        check("rst.s_wdata", s_wdata, 0);
        check("rst.s_wstrb", {28'b0, s_wstrb}, 0);
        check("rst.m0_pulses", pulses(1'b0), 0);
        check("rst.m1_pulses", pulses(1'b1), 0);
        check("rst.m0_rdata", m0_rdata, 0);
        check("rst.m1_rdata", m1_rdata, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // First tie right after reset: m0 first, then m1
        drive_master(1'b0, 1'b1, 1'b0, 32'h1000, '0, '0, '0);
        drive_master(1'b1, 1'b1, 1'b0, 32'h1100, '0, '0, '0);
        serve_read("tie1.first", 1'b0, 32'h1000, 32'h1111_1111);
        serve_read("tie1.second", 1'b1, 32'h1100, 32'h2222_2222);

        // m0 alone, so m0 becomes the last grant
        solo = '{mst:1'b0, wr:1'b0, addr:32'h1200, wdata:32'h0, strb:4'h0, delay:1,
                 resp:32'h3333_3333, exp_err:1'b0, exp_rdata:32'h3333_3333};
        run_txn("solo_m0", solo);

        // Second tie: m1 wins now
        drive_master(1'b0, 1'b1, 1'b0, 32'h1300, '0, '0, '0);
        drive_master(1'b1, 1'b1, 1'b0, 32'h1400, '0, '0, '0);
        serve_read("tie2.first", 1'b1, 32'h1400, 32'h4444_4444);
        serve_read("tie2.second", 1'b0, 32'h1300, 32'h5555_5555);

        // Table of single transactions
        foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Read and write from the same master: read first, write afterwards
        drive_master(1'b0, 1'b1, 1'b1, 32'h800, 32'h804, 32'h7777_8888, 4'hC);
        step();
        check("rw.read_first", {30'b0, s_ren, s_wen}, 2);
        check("rw.s_raddr", s_raddr, 32'h800);
        s_rvalid = 1'b1;
        s_rdata  = 32'h7070_7070;
        step();
        s_rvalid = 1'b0;
        check("rw.read_pulse", pulses(1'b0), 3'b100);
        step();
        m0_ren = 1'b0;
        check("rw.idle_gap", {30'b0, s_ren, s_wen}, 0);
        step();
        check("rw.write_next", {30'b0, s_ren, s_wen}, 1);
        check("rw.s_waddr", s_waddr, 32'h804);
        check("rw.s_wdata", s_wdata, 32'h7777_8888);
        check("rw.s_wstrb", {28'b0, s_wstrb}, 32'hC);
        s_wready = 1'b1;
        step();
        s_wready = 1'b0;
        check("rw.write_pulse", pulses(1'b0), 3'b010);
        check("rw.rdata_hold", m0_rdata, 32'h7070_7070);
        step();
        m0_wen = 1'b0;
        step();

        // Reset in the middle of a read
        drive_master(1'b0, 1'b1, 1'b0, 32'h900, '0, '0, '0);
        step();
        check("rstmid.s_ren", {31'b0, s_ren}, 1);
        step();
        step();
        #3;
        resetn = 1'b0;
        #1;
        check("rstmid.s_ren_async", {31'b0, s_ren}, 0);
        check("rstmid.m0_rdata", m0_rdata, 0);
        check("rstmid.m1_rdata", m1_rdata, 0);
        m0_ren = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rstmid.quiet%0d", i), {26'b0, pulses(1'b0), pulses(1'b1)}, 0);
        end
        solo = '{mst:1'b1, wr:1'b0, addr:32'hA00, wdata:32'h0, strb:4'h0, delay:2,
                 resp:32'h9999_0000, exp_err:1'b0, exp_rdata:32'h9999_0000};
        run_txn("after_rst_m1", solo);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_bus_arbiter

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low, with ports named clock and resetn.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the data width; strobe width SHALL be DATA_W/8.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the maximum cycles awaiting a slave response; 0 SHALL disable the timeout.
REQ-005 Ports SHALL be:
- clock  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mN_ren  in  1  master N read request (N in {0,1}), held until the response
- mN_raddr  in  ADDR_W  master N read address
- mN_rdata  out  DATA_W  master N read data
- mN_rvalid  out  1  master N read-done pulse
- mN_wen  in  1  master N write request, held until the response
- mN_waddr  in  ADDR_W  master N write address
- mN_wdata  in  DATA_W  master N write data
- mN_wstrb  in  DATA_W/8  master N byte strobes
- mN_wready  out  1  master N write-done pulse
- mN_err  out  1  master N timeout pulse, coincident with rvalid or wready
- s_ren, s_raddr  out  1, ADDR_W  shared-port read request and address
- s_rdata, s_rvalid  in  DATA_W, 1  shared-port read data and response
- s_wen, s_waddr, s_wdata, s_wstrb  out  1, ADDR_W, DATA_W, DATA_W/8  shared-port write request, address, data and strobes
- s_wready  in  1  shared-port write response

Function
REQ-006 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-007 IDLE SHALL sample requests at each clock edge; if any master requests, the FSM SHALL latch the owner and go to READ or WRITE.
REQ-008 Arbitration SHALL be two-way round-robin: on a tie, the master not granted last SHALL win, and last_grant SHALL update on every grant.
REQ-009 A master asserting both ren and wen SHALL be served its read first; its write SHALL compete in a later arbitration.
REQ-010 All s_* outputs SHALL be registered; s_ren or s_wen SHALL assert in the first cycle of READ or WRITE with the owner's address, data and strobes latched at grant.
REQ-011 s_* outputs SHALL remain stable until s_rvalid or s_wready is sampled high, then deassert on the next cycle as the FSM enters RESP.
REQ-012 In RESP, only the owner's rvalid or wready SHALL pulse high for exactly one cycle; mN_rdata SHALL carry the latched s_rdata, and the FSM SHALL go to IDLE next.
REQ-013 Request-to-shared-port latency SHALL be 1 cycle, and slave-response-to-master-pulse latency SHALL be 1 cycle.
REQ-014 A master SHALL deassert its request in the cycle after its response pulse; IDLE SHALL NOT re-grant in the RESP cycle.
REQ-015 If TIMEOUT is greater than 0 and TIMEOUT cycles elapse in READ or WRITE without a response, the block SHALL drop s_ren or s_wen and enter RESP.
- The owner SHALL then receive rvalid or wready together with mN_err.
- mN_rdata SHALL equal ERR_DATA (32'hDEAD_BEEF).
REQ-016 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide, SHALL clear on entry to READ or WRITE, and SHALL saturate without wrapping.
REQ-017 A response arriving in the same cycle the timeout fires SHALL take precedence, and mN_err SHALL stay 0.
REQ-018 When not in RESP, mN_rdata SHALL hold its last value and all pulses SHALL be 0.
REQ-019 The non-owner's requests SHALL be ignored until the FSM returns to IDLE; no request SHALL be dropped or reordered within a master.

Reset
REQ-020 Asserting resetn low SHALL immediately force IDLE, last_grant=1 (so m0 wins the first tie), the counter to 0, every output to 0 and mN_rdata to 0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction with no response pulse.
REQ-022 Reset SHALL release synchronously to clock.

Structure
REQ-023 A package mem_bus_pkg SHALL hold the state enum, ERR_DATA and the request struct (addr, wdata, wstrb, is_write).
REQ-024 The round-robin pick SHALL be a sub-module rr_arbiter_2, taking req[1:0] and last_grant and producing a one-hot grant.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single read: m0_ren with addr 0x100 and a slave responding with 0x12345678 after 3 cycles -> m0_rvalid pulses 1 cycle after s_rvalid with rdata 0x12345678, and m1 outputs stay quiet.
- Tie: m0 and m1 both ren in the first cycle after reset -> m0 granted first, then m1; a second tie -> m1 granted first.
- Write: m1_wen with addr 0x200, data 0xA5A5A5A5, wstrb 0x3 -> s_* match exactly and m1_wready pulses once.
- Timeout: TIMEOUT=8 with the slave silent -> s_ren drops after 8 cycles, m0_rvalid and m0_err pulse, and m0_rdata=0xDEADBEEF.
- Reset mid-read: resetn low while in READ -> s_ren drops to 0 asynchronously, no rvalid occurs, and a fresh m1 request after release is granted.
- Read and write together: m0 ren+wen -> read completes first, then the write in a separate transaction.
